// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the PLL reset and the downstream system reset for the
//   pll_wrapper clock path: pulses the PLL reset, waits for a debounced
//   lock, then releases the system reset. Lock timeouts trigger retries.
//   Too many retries park the sequencer in FAIL with a sticky error.
//   Software can request a re-lock (cfg_req/cfg_ack). Loss of lock while
//   running re-holds the system reset without pulsing the PLL.
//
// Ports
//   clk_in         reference clock, all state on rising edge
//   reset_in       asynchronous active-high reset
//   pll_locked_in  PLL lock indicator
//   cfg_req        re-lock request (level, held until cfg_ack)
//   cfg_ack        one-cycle pulse when a requested re-lock completes
//   pll_reset_out  reset to the PLL, active-high
//   sys_reset_out  downstream system reset, active-high
//   lock_err       sticky retry-exhaustion flag
//   retry_count    retries in the current sequence
//   state_out      PLL_RST=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
//
// Build option
//   PLL_SEQ_LOCK_SYNC_EN : when defined, pll_locked_in passes through a
//   2-flop synchronizer before use. When undefined, pll_locked_in must
//   already be in the clk_in domain.

module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT       = 4096,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic                               pll_locked_in,
    input  logic                               cfg_req,
    output logic                               cfg_ack,
    output logic                               pll_reset_out,
    output logic                               sys_reset_out,
    output logic                               lock_err,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         state_out
);

    localparam int unsigned RCW = $clog2(PLL_RST_CYCLES + 1);
    localparam int unsigned TMW = $clog2(LOCK_TIMEOUT);
    localparam int unsigned SCW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned RTW = $clog2(MAX_RETRIES + 1);

    localparam logic [RCW-1:0] RST_LAST  = RCW'(PLL_RST_CYCLES);
    localparam logic [RCW-1:0] RST_FIRST = RCW'(1);
    localparam logic [TMW-1:0] TMO_LAST  = TMW'(LOCK_TIMEOUT - 1);
    localparam logic [TMW-1:0] TMO_ONE   = TMW'(1);
    localparam logic [SCW-1:0] STB_DONE  = SCW'(LOCK_STABLE_CYCLES);
    localparam logic [SCW-1:0] STB_ONE   = SCW'(1);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRIES);
    localparam logic [RTW-1:0] RETRY_ONE = RTW'(1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t         state, state_nx;
    logic [RCW-1:0] rst_cnt, rst_cnt_nx;
    logic [TMW-1:0] timer, timer_nx;
    logic [SCW-1:0] stable_cnt, stable_nx;
    logic [RTW-1:0] retry_nx;
    logic           pending, pending_nx;
    logic           ack_nx;
    logic           expire;
    logic           locked;

`ifdef PLL_SEQ_LOCK_SYNC_EN
    logic lock_meta, lock_sync;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked_in;
            lock_sync <= lock_meta;
        end
    end

    assign locked = lock_sync;
`else
    assign locked = pll_locked_in;
`endif

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        timer_nx   = timer;
        stable_nx  = stable_cnt;
        retry_nx   = retry_count;
        pending_nx = pending;
        expire     = 1'b0;

        case (state)
            ST_PLL_RST: begin
                timer_nx  = '0;
                stable_nx = '0;
                // Reset leaves the count at 0, so the first post-reset pulse
                // covers the reset period plus PLL_RST_CYCLES clocks. Entries
                // from other states preload 1, giving exactly PLL_RST_CYCLES.
                if (rst_cnt == RST_LAST) begin
                    state_nx   = ST_WAIT_LOCK;
                    rst_cnt_nx = '0;
                end else begin
                    rst_cnt_nx = rst_cnt + RST_FIRST;
                end
            end
            ST_WAIT_LOCK: begin
                if (timer == TMO_LAST) begin
                    expire = 1'b1;
                end else begin
                    timer_nx = timer + TMO_ONE;
                    if (locked) begin
                        state_nx  = ST_STABLE;
                        stable_nx = STB_ONE;
                    end
                end
            end
            ST_STABLE: begin
                // Reaching the stable count wins over a coincident timeout.
                if (stable_cnt == STB_DONE) begin
                    state_nx = ST_RUN;
                    retry_nx = '0;
                end else if (timer == TMO_LAST) begin
                    expire = 1'b1;
                end else begin
                    timer_nx = timer + TMO_ONE;
                    if (locked) begin
                        stable_nx = stable_cnt + STB_ONE;
                    end else begin
                        stable_nx = '0;
                        state_nx  = ST_WAIT_LOCK;
                    end
                end
            end
            ST_RUN: begin
                // A re-lock request wins over a coincident lock loss.
                if (cfg_req) begin
                    state_nx   = ST_PLL_RST;
                    rst_cnt_nx = RST_FIRST;
                    pending_nx = 1'b1;
                end else if (!locked) begin
                    state_nx  = ST_WAIT_LOCK;
                    timer_nx  = '0;
                    stable_nx = '0;
                end
            end
            ST_FAIL: begin
                if (cfg_req) begin
                    state_nx   = ST_PLL_RST;
                    rst_cnt_nx = RST_FIRST;
                    pending_nx = 1'b1;
                    retry_nx   = '0;
                end
            end
            default: begin
                state_nx   = ST_PLL_RST;
                rst_cnt_nx = RST_FIRST;
            end
        endcase

        if (expire) begin
            retry_nx   = retry_count + RETRY_ONE;
            state_nx   = (retry_nx == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
            rst_cnt_nx = RST_FIRST;
            timer_nx   = '0;
            stable_nx  = '0;
        end

        ack_nx = pending && (state_nx == ST_RUN) && (state != ST_RUN);
        if (ack_nx) begin
            pending_nx = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with state_out.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state         <= ST_PLL_RST;
            rst_cnt       <= '0;
            timer         <= '0;
            stable_cnt    <= '0;
            retry_count   <= '0;
            pending       <= 1'b0;
            cfg_ack       <= 1'b0;
            pll_reset_out <= 1'b1;
            sys_reset_out <= 1'b1;
            lock_err      <= 1'b0;
        end else begin
            state         <= state_nx;
            rst_cnt       <= rst_cnt_nx;
            timer         <= timer_nx;
            stable_cnt    <= stable_nx;
            retry_count   <= retry_nx;
            pending       <= pending_nx;
            cfg_ack       <= ack_nx;
            pll_reset_out <= (state_nx == ST_PLL_RST);
            sys_reset_out <= (state_nx != ST_RUN);
            lock_err      <= (state_nx == ST_FAIL);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2. Cycle k is the
// state after the k-th rising edge following reset release. Inputs change
// and outputs are sampled on the falling edge.

module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_LOCK_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic       clk_in;
    logic       reset_in;
    logic       pll_locked_in;
    logic       cfg_req;
    logic       cfg_ack;
    logic       pll_reset_out;
    logic       sys_reset_out;
    logic       lock_err;
    logic [1:0] retry_count;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT       (32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .pll_locked_in (pll_locked_in),
        .cfg_req       (cfg_req),
        .cfg_ack       (cfg_ack),
        .pll_reset_out (pll_reset_out),
        .sys_reset_out (sys_reset_out),
        .lock_err      (lock_err),
        .retry_count   (retry_count),
        .state_out     (state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic do_reset();
        reset_in      = 1'b1;
        cfg_req       = 1'b0;
        pll_locked_in = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in      = 1'b1;
        cfg_req       = 1'b0;
        pll_locked_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state_out); end
        n_checks++; if (pll_reset_out !== 1'b1) begin n_fail++; $display("FAIL rst_pll got=%b exp=1", pll_reset_out); end
        n_checks++; if (sys_reset_out !== 1'b1) begin n_fail++; $display("FAIL rst_sys got=%b exp=1", sys_reset_out); end
        n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", cfg_ack); end
        n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", lock_err); end
        n_checks++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL rst_retry got=%0d exp=0", retry_count); end
    endtask

    task automatic test_power_up();
        logic [2:0] e_st;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            pll_locked_in = (k >= 6);
            @(negedge clk_in);
            if (k <= 4) e_st = 3'd0;
            else if (k <= 5 + LAG) e_st = 3'd1;
            else if (k <= 13 + LAG) e_st = 3'd2;
            else e_st = 3'd3;
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL pu_state k=%0d got=%0d exp=%0d", k, state_out, e_st); end
            n_checks++; if (pll_reset_out !== (k <= 4)) begin n_fail++; $display("FAIL pu_pll k=%0d got=%b exp=%b", k, pll_reset_out, (k <= 4)); end
            n_checks++; if (sys_reset_out !== (k < 14 + LAG)) begin n_fail++; $display("FAIL pu_sys k=%0d got=%b exp=%b", k, sys_reset_out, (k < 14 + LAG)); end
            n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL pu_ack k=%0d got=%b exp=0", k, cfg_ack); end
        end
    endtask

    task automatic test_lock_glitch();
        logic [2:0] e_st;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            pll_locked_in = (k >= 6) && (k != 11);
            @(negedge clk_in);
            if (k <= 4) e_st = 3'd0;
            else if (k <= 5 + LAG) e_st = 3'd1;
            else if (k <= 10 + LAG) e_st = 3'd2;
            else if (k == 11 + LAG) e_st = 3'd1;
            else if (k <= 19 + LAG) e_st = 3'd2;
            else e_st = 3'd3;
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL gl_state k=%0d got=%0d exp=%0d", k, state_out, e_st); end
            n_checks++; if (sys_reset_out !== (k < 20 + LAG)) begin n_fail++; $display("FAIL gl_sys k=%0d got=%b exp=%b", k, sys_reset_out, (k < 20 + LAG)); end
            n_checks++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL gl_retry k=%0d got=%0d exp=0", k, retry_count); end
        end
    endtask

    task automatic test_timeout_retry();
        logic [2:0] e_st;
        logic [1:0] e_rt;
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            pll_locked_in = 1'b0;
            @(negedge clk_in);
            if (k <= 4) e_st = 3'd0;
            else if (k <= 36) e_st = 3'd1;
            else if (k <= 40) e_st = 3'd0;
            else if (k <= 72) e_st = 3'd1;
            else e_st = 3'd4;
            e_rt = (k < 37) ? 2'd0 : ((k < 73) ? 2'd1 : 2'd2);
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL to_state k=%0d got=%0d exp=%0d", k, state_out, e_st); end
            n_checks++; if (retry_count !== e_rt) begin n_fail++; $display("FAIL to_retry k=%0d got=%0d exp=%0d", k, retry_count, e_rt); end
            n_checks++; if (pll_reset_out !== (e_st == 3'd0)) begin n_fail++; $display("FAIL to_pll k=%0d got=%b exp=%b", k, pll_reset_out, (e_st == 3'd0)); end
            n_checks++; if (sys_reset_out !== 1'b1) begin n_fail++; $display("FAIL to_sys k=%0d got=%b exp=1", k, sys_reset_out); end
            n_checks++; if (lock_err !== (k >= 73)) begin n_fail++; $display("FAIL to_err k=%0d got=%b exp=%b", k, lock_err, (k >= 73)); end
        end
    endtask

    // Starts in FAIL, left there by test_timeout_retry.
    task automatic test_fail_recovery();
        logic [2:0] e_st;
        logic       ack_seen = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            cfg_req       = !ack_seen;
            pll_locked_in = 1'b1;
            @(negedge clk_in);
            if (cfg_ack) ack_seen = 1'b1;
            if (r <= 4) e_st = 3'd0;
            else if (r == 5) e_st = 3'd1;
            else if (r <= 13) e_st = 3'd2;
            else e_st = 3'd3;
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL fr_state r=%0d got=%0d exp=%0d", r, state_out, e_st); end
            n_checks++; if (pll_reset_out !== (r <= 4)) begin n_fail++; $display("FAIL fr_pll r=%0d got=%b exp=%b", r, pll_reset_out, (r <= 4)); end
            n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL fr_err r=%0d got=%b exp=0", r, lock_err); end
            n_checks++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL fr_retry r=%0d got=%0d exp=0", r, retry_count); end
            n_checks++; if (cfg_ack !== (r == 14)) begin n_fail++; $display("FAIL fr_ack r=%0d got=%b exp=%b", r, cfg_ack, (r == 14)); end
            n_checks++; if (sys_reset_out !== (r < 14)) begin n_fail++; $display("FAIL fr_sys r=%0d got=%b exp=%b", r, sys_reset_out, (r < 14)); end
        end
        cfg_req = 1'b0;
    endtask

    // Starts in RUN, left there by test_fail_recovery.
    task automatic test_run_lock_loss();
        logic [2:0] e_st;
        for (int m = 1; m <= 14; m++) begin
            cfg_req       = 1'b0;
            pll_locked_in = (m > 3);
            @(negedge clk_in);
            if (m <= LAG) e_st = 3'd3;
            else if (m <= 3 + LAG) e_st = 3'd1;
            else if (m <= 11 + LAG) e_st = 3'd2;
            else e_st = 3'd3;
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL ll_state m=%0d got=%0d exp=%0d", m, state_out, e_st); end
            n_checks++; if (pll_reset_out !== 1'b0) begin n_fail++; $display("FAIL ll_pll m=%0d got=%b exp=0", m, pll_reset_out); end
            n_checks++; if (sys_reset_out !== (e_st != 3'd3)) begin n_fail++; $display("FAIL ll_sys m=%0d got=%b exp=%b", m, sys_reset_out, (e_st != 3'd3)); end
            n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL ll_ack m=%0d got=%b exp=0", m, cfg_ack); end
        end
    endtask

    // Starts in RUN, left there by test_run_lock_loss.
    task automatic test_simultaneous();
        logic [2:0] e_st;
        logic       ack_seen = 1'b0;
        pll_locked_in = 1'b0;
        cfg_req       = 1'b1;
        @(negedge clk_in);
        n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL sim_state got=%0d exp=0", state_out); end
        n_checks++; if (pll_reset_out !== 1'b1) begin n_fail++; $display("FAIL sim_pll got=%b exp=1", pll_reset_out); end
        n_checks++; if (sys_reset_out !== 1'b1) begin n_fail++; $display("FAIL sim_sys got=%b exp=1", sys_reset_out); end
        for (int r = 2; r <= 16; r++) begin
            cfg_req       = !ack_seen;
            pll_locked_in = 1'b1;
            @(negedge clk_in);
            if (cfg_ack) ack_seen = 1'b1;
            if (r <= 4) e_st = 3'd0;
            else if (r == 5) e_st = 3'd1;
            else if (r <= 13) e_st = 3'd2;
            else e_st = 3'd3;
            n_checks++; if (state_out !== e_st) begin n_fail++; $display("FAIL sim_seq r=%0d got=%0d exp=%0d", r, state_out, e_st); end
            n_checks++; if (cfg_ack !== (r == 14)) begin n_fail++; $display("FAIL sim_ack r=%0d got=%b exp=%b", r, cfg_ack, (r == 14)); end
        end
        cfg_req = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 1; k <= 8 + LAG; k++) begin
            pll_locked_in = (k >= 6);
            @(negedge clk_in);
        end
        n_checks++; if (state_out !== 3'd2) begin n_fail++; $display("FAIL ar_pre got=%0d exp=2", state_out); end
        #2 reset_in = 1'b1;
        #1;
        n_checks++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL ar_state got=%0d exp=0", state_out); end
        n_checks++; if (pll_reset_out !== 1'b1) begin n_fail++; $display("FAIL ar_pll got=%b exp=1", pll_reset_out); end
        n_checks++; if (sys_reset_out !== 1'b1) begin n_fail++; $display("FAIL ar_sys got=%b exp=1", sys_reset_out); end
        n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL ar_ack got=%b exp=0", cfg_ack); end
        n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL ar_err got=%b exp=0", lock_err); end
        n_checks++; if (retry_count !== 2'd0) begin n_fail++; $display("FAIL ar_retry got=%0d exp=0", retry_count); end
        @(negedge clk_in);
        reset_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_timeout_retry();
        test_fail_recovery();
        test_run_lock_loss();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
